ps2_controller: RTL and testbench
=================================

Name: ps2_controller

Overview:
- PS/2 keyboard receiver that decodes scan-code set 2 into Gigatron input bytes.
- Translated keys produce ASCII codes; arrow keys produce active-low gamepad patterns.
- Holds one decoded byte with a ready/ack handshake toward the serial-gamepad shifter in the top level.
- Also drives a 16-bit debug word selected by switches.

Parameters:
- TIMEOUT_CYCLES, 5000: CLOCK_50 cycles (100 us) of PS2_CLK inactivity mid-frame after which a partial frame is discarded.

Ports:
- CLOCK_50 in 1: system clock, 50 MHz; sole clock domain.
- reset_n in 1: asynchronous active-low reset.
- clk1 in 1: CPU phase 1; sampled only for debug; no functional effect.
- clk2 in 1: CPU phase 2; sampled only for debug; no functional effect.
- dbg_sel in 3: debug word select.
- dbg out 16: debug word.
- ps2_clk in 1: PS/2 clock from the keyboard; asynchronous.
- ps2_dat in 1: PS/2 data from the keyboard; asynchronous.
- data out 8: decoded byte.
- ready out 1: data valid.
- ack in 1: high while the consumer is shifting data out.

Behaviour:
- Reset values: data=8'hFF, ready=0, dbg=0, frame state idle, break/extended/shift flags clear.
- ps2_clk and ps2_dat pass through 2-FF synchronizers. A falling edge is detected from the synchronized clock.
- Frame reception, one bit per falling edge:
  - Start bit must be 0, else the frame is dropped.
  - 8 data bits, LSB first.
  - Odd parity bit.
  - Stop bit must be 1.
- A complete, valid frame yields a scan byte one cycle after the stop-bit edge.
- A parity or stop error drops the byte and increments an 8-bit wrapping error counter.
- If no falling edge arrives within TIMEOUT_CYCLES while mid-frame, the receiver returns to idle without output.
- Decoder rules:
  - E0 sets the extended flag.
  - F0 sets the break flag.
  - Any other code consumes both flags after use.
  - Break of 12/59 clears shift; make of 12/59 sets shift.
  - All other breaks produce nothing.
- Non-extended make codes, standard set-2 table:
  - Letters A–Z: ASCII lowercase, or uppercase when shift is set (1C→'a'/'A', 32→'b', 1A→'z').
  - Digits 0–9: 45→'0', 16→'1' … 46→'9'.
  - 29→0x20, 5A→0x0A, 66→0x7F, 76→0x1B.
- Extended make codes, active-low gamepad: E0 74→8'hFE (right), E0 6B→8'hFD (left), E0 72→8'hFB (down), E0 75→8'hF7 (up).
- Unmapped codes produce nothing.
- Handshake:
  - A produced byte loads data and sets ready only if ready=0. If ready=1, the new byte is dropped, counted in the overflow counter (8-bit, wrapping).
  - The consumer raises ack when it latches data and lowers it after shifting.
  - ready clears on the falling edge of ack (synchronized).
  - data keeps its last value after ready clears.
  - A produce and an ack-fall in the same cycle: the clear applies first, then the load. Net ready=1 with the new data.
- Debug word, registered:
  - dbg_sel 0: {last scan byte, data}.
  - dbg_sel 1: {frame count, error count}.
  - dbg_sel 2: {overflow count, 4'b0, bit index}.
  - dbg_sel 3: {13'b0, shift, extended, break}.
  - dbg_sel 4: {14'b0, clk2, clk1}.
  - dbg_sel 5–7: 16'h0000.
  - The frame count is 8-bit, wrapping, and counts valid frames.
- Reset asserted mid-frame or mid-handshake returns all state to reset values immediately.

Optional Feature:
- Macro PS2_FIFO_EN.
- Defined: decoded bytes enter a 4-entry FIFO. ready is FIFO not-empty and data is the FIFO head. An ack falling edge pops the head. A push to a full FIFO is dropped and counted as overflow. Simultaneous push and pop on a full FIFO is accepted.
- Undefined: single holding register as described above.

Test Plan:
- Frame 1C with valid odd parity -> data=8'h61, ready=1 ~1 cycle after the stop edge. Then ack 1→0 -> ready=0 and data stays 8'h61.
- Sequence 12, 1C, F0 1C, F0 12, 1C -> outputs 8'h41, then 8'h61 (ack between bytes).
- E0 75, then E0 F0 75 -> data=8'hF7 once; the break produces nothing. Extended and break flags are clear afterwards.
- Frame with a bad parity bit -> no ready, error count increments to 1. A frame with stop=0 increments it to 2.
- Four clock edges then 6000 idle cycles, then a valid 29 frame -> data=8'h20 (timeout recovered).
- With ready=1 and no ack, send 16 -> data stays, overflow count=1. With PS2_FIFO_EN, 16 is queued and appears as 8'h31 after the ack fall.

Source files
------------

// File: rtl/ps2_controller.sv
// PS/2 set-2 keyboard receiver producing Gigatron input bytes (ASCII or active-low gamepad).
// Define PS2_FIFO_EN to buffer decoded bytes in a 4-entry FIFO instead of a single holding register.
module ps2_controller #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        clk1,
  input  logic        clk2,
  input  logic [2:0]  dbg_sel,
  output logic [15:0] dbg,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [7:0]  data,
  output logic        ready,
  input  logic        ack
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]         ps2_clk_sync_reg, ps2_dat_sync_reg, ack_sync_reg;
  logic               ps2_clk_prev_reg, ack_prev_reg;
  logic               ps2_fall, ack_fall, ps2_dat_s;
  logic [1:0]         state_reg;
  logic [3:0]         bit_idx_reg;
  logic [7:0]         rx_shift_reg;
  logic               parity_ok_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic [7:0]         scan_byte_reg;
  logic               scan_valid_reg;
  logic [7:0]         frame_cnt_reg, err_cnt_reg, ovf_cnt_reg;
  logic               brk_reg, ext_reg, shift_key_reg;
  logic               prod_valid_reg;
  logic [7:0]         prod_byte_reg;
  logic               map_valid;
  logic [7:0]         map_byte;
  logic [5:0]         letter;
  logic [4:0]         digit;
  logic [7:0]         data_reg;
  logic               ready_reg;

  assign ps2_fall  = ps2_clk_prev_reg & ~ps2_clk_sync_reg[1];
  assign ack_fall  = ack_prev_reg & ~ack_sync_reg[1];
  assign ps2_dat_s = ps2_dat_sync_reg[1];
  assign data      = data_reg;
  assign ready     = ready_reg;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clk_sync_reg <= 2'b11;
      ps2_dat_sync_reg <= 2'b11;
      ack_sync_reg     <= 2'b00;
      ps2_clk_prev_reg <= 1'b1;
      ack_prev_reg     <= 1'b0;
    end else begin
      ps2_clk_sync_reg <= {ps2_clk_sync_reg[0], ps2_clk};
      ps2_dat_sync_reg <= {ps2_dat_sync_reg[0], ps2_dat};
      ack_sync_reg     <= {ack_sync_reg[0], ack};
      ps2_clk_prev_reg <= ps2_clk_sync_reg[1];
      ack_prev_reg     <= ack_sync_reg[1];
    end
  end

  // Frame receiver: one bit per PS/2 falling edge, watchdog aborts stalled frames.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      bit_idx_reg    <= 4'd0;
      rx_shift_reg   <= 8'h00;
      parity_ok_reg  <= 1'b0;
      timer_reg      <= '0;
      scan_byte_reg  <= 8'h00;
      scan_valid_reg <= 1'b0;
      frame_cnt_reg  <= 8'h00;
      err_cnt_reg    <= 8'h00;
    end else begin
      scan_valid_reg <= 1'b0;
      if (ps2_fall) begin
        timer_reg <= '0;
        case (state_reg)
          ST_IDLE: begin
            bit_idx_reg <= 4'd0;
            if (!ps2_dat_s) state_reg <= ST_DATA;
          end
          ST_DATA: begin
            rx_shift_reg <= {ps2_dat_s, rx_shift_reg[7:1]};
            bit_idx_reg  <= bit_idx_reg + 4'd1;
            if (bit_idx_reg == 4'd7) state_reg <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_ok_reg <= ^{rx_shift_reg, ps2_dat_s};
            state_reg     <= ST_STOP;
          end
          default: begin
            state_reg   <= ST_IDLE;
            bit_idx_reg <= 4'd0;
            if (ps2_dat_s && parity_ok_reg) begin
              scan_byte_reg  <= rx_shift_reg;
              scan_valid_reg <= 1'b1;
              frame_cnt_reg  <= frame_cnt_reg + 8'd1;
            end else begin
              err_cnt_reg <= err_cnt_reg + 8'd1;
            end
          end
        endcase
      end else if (state_reg != ST_IDLE) begin
        if (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          state_reg   <= ST_IDLE;
          bit_idx_reg <= 4'd0;
          timer_reg   <= '0;
        end else begin
          timer_reg <= timer_reg + 1'b1;
        end
      end
    end
  end

  function automatic logic [5:0] letter_idx(input logic [7:0] code);
    case (code)
      8'h1C: letter_idx = {1'b1, 5'd0};   8'h32: letter_idx = {1'b1, 5'd1};
      8'h21: letter_idx = {1'b1, 5'd2};   8'h23: letter_idx = {1'b1, 5'd3};
      8'h24: letter_idx = {1'b1, 5'd4};   8'h2B: letter_idx = {1'b1, 5'd5};
      8'h34: letter_idx = {1'b1, 5'd6};   8'h33: letter_idx = {1'b1, 5'd7};
      8'h43: letter_idx = {1'b1, 5'd8};   8'h3B: letter_idx = {1'b1, 5'd9};
      8'h42: letter_idx = {1'b1, 5'd10};  8'h4B: letter_idx = {1'b1, 5'd11};
      8'h3A: letter_idx = {1'b1, 5'd12};  8'h31: letter_idx = {1'b1, 5'd13};
      8'h44: letter_idx = {1'b1, 5'd14};  8'h4D: letter_idx = {1'b1, 5'd15};
      8'h15: letter_idx = {1'b1, 5'd16};  8'h2D: letter_idx = {1'b1, 5'd17};
      8'h1B: letter_idx = {1'b1, 5'd18};  8'h2C: letter_idx = {1'b1, 5'd19};
      8'h3C: letter_idx = {1'b1, 5'd20};  8'h2A: letter_idx = {1'b1, 5'd21};
      8'h1D: letter_idx = {1'b1, 5'd22};  8'h22: letter_idx = {1'b1, 5'd23};
      8'h35: letter_idx = {1'b1, 5'd24};  8'h1A: letter_idx = {1'b1, 5'd25};
      default: letter_idx = 6'd0;
    endcase
  endfunction

  function automatic logic [4:0] digit_idx(input logic [7:0] code);
    case (code)
      8'h45: digit_idx = {1'b1, 4'd0};  8'h16: digit_idx = {1'b1, 4'd1};
      8'h1E: digit_idx = {1'b1, 4'd2};  8'h26: digit_idx = {1'b1, 4'd3};
      8'h25: digit_idx = {1'b1, 4'd4};  8'h2E: digit_idx = {1'b1, 4'd5};
      8'h36: digit_idx = {1'b1, 4'd6};  8'h3D: digit_idx = {1'b1, 4'd7};
      8'h3E: digit_idx = {1'b1, 4'd8};  8'h46: digit_idx = {1'b1, 4'd9};
      default: digit_idx = 5'd0;
    endcase
  endfunction

  assign letter = letter_idx(scan_byte_reg);
  assign digit  = digit_idx(scan_byte_reg);

  always_comb begin
    map_valid = 1'b0;
    map_byte  = 8'h00;
    if (ext_reg) begin
      case (scan_byte_reg)
        8'h74: begin map_valid = 1'b1; map_byte = 8'hFE; end
        8'h6B: begin map_valid = 1'b1; map_byte = 8'hFD; end
        8'h72: begin map_valid = 1'b1; map_byte = 8'hFB; end
        8'h75: begin map_valid = 1'b1; map_byte = 8'hF7; end
        default: ;
      endcase
    end else if (letter[5]) begin
      map_valid = 1'b1;
      map_byte  = (shift_key_reg ? 8'h41 : 8'h61) + {3'b000, letter[4:0]};
    end else if (digit[4]) begin
      map_valid = 1'b1;
      map_byte  = 8'h30 + {4'b0000, digit[3:0]};
    end else begin
      case (scan_byte_reg)
        8'h29: begin map_valid = 1'b1; map_byte = 8'h20; end
        8'h5A: begin map_valid = 1'b1; map_byte = 8'h0A; end
        8'h66: begin map_valid = 1'b1; map_byte = 8'h7F; end
        8'h76: begin map_valid = 1'b1; map_byte = 8'h1B; end
        default: ;
      endcase
    end
  end

  // Prefix bytes arm the flags; every other code consumes them.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      brk_reg        <= 1'b0;
      ext_reg        <= 1'b0;
      shift_key_reg  <= 1'b0;
      prod_valid_reg <= 1'b0;
      prod_byte_reg  <= 8'h00;
    end else begin
      prod_valid_reg <= 1'b0;
      if (scan_valid_reg) begin
        if (scan_byte_reg == 8'hE0) begin
          ext_reg <= 1'b1;
        end else if (scan_byte_reg == 8'hF0) begin
          brk_reg <= 1'b1;
        end else begin
          brk_reg <= 1'b0;
          ext_reg <= 1'b0;
          if (scan_byte_reg == 8'h12 || scan_byte_reg == 8'h59) begin
            shift_key_reg <= ~brk_reg;
          end else if (!brk_reg && map_valid) begin
            prod_valid_reg <= 1'b1;
            prod_byte_reg  <= map_byte;
          end
        end
      end
    end
  end

`ifdef PS2_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [2:0] count_reg, count_next;
  logic       pop, push_ok;
  logic [7:0] head_next;

  always_comb begin
    pop         = ack_fall && (count_reg != 3'd0);
    push_ok     = prod_valid_reg && ((count_reg != 3'd4) || pop);
    count_next  = count_reg + {2'b00, push_ok} - {2'b00, pop};
    rd_ptr_next = rd_ptr_reg + {1'b0, pop};
    // An emptied queue takes its new head straight from the incoming byte.
    head_next   = (count_reg == {2'b00, pop}) ? prod_byte_reg : fifo_mem[rd_ptr_next];
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) fifo_mem[wr_ptr_reg] <= prod_byte_reg;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= 2'd0;
      rd_ptr_reg  <= 2'd0;
      count_reg   <= 3'd0;
      data_reg    <= 8'hFF;
      ready_reg   <= 1'b0;
      ovf_cnt_reg <= 8'h00;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (prod_valid_reg && !push_ok) ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ready_reg  <= (count_next != 3'd0);
      if (count_next != 3'd0) data_reg <= head_next;
    end
  end
`else
  // Ack fall is applied before a same-cycle load, so that load is accepted.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      data_reg    <= 8'hFF;
      ready_reg   <= 1'b0;
      ovf_cnt_reg <= 8'h00;
    end else begin
      if (ack_fall) ready_reg <= 1'b0;
      if (prod_valid_reg) begin
        if (!ready_reg || ack_fall) begin
          data_reg  <= prod_byte_reg;
          ready_reg <= 1'b1;
        end else begin
          ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
        end
      end
    end
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      dbg <= 16'h0000;
    end else begin
      case (dbg_sel)
        3'd0:    dbg <= {scan_byte_reg, data_reg};
        3'd1:    dbg <= {frame_cnt_reg, err_cnt_reg};
        3'd2:    dbg <= {ovf_cnt_reg, 4'b0000, bit_idx_reg};
        3'd3:    dbg <= {13'b0, shift_key_reg, ext_reg, brk_reg};
        3'd4:    dbg <= {14'b0, clk2, clk1};
        default: dbg <= 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_controller.sv
// Scoreboard bench for ps2_controller: random PS/2 frames against a table-driven key model.
module tb_ps2_controller;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk1 = 1'b0, clk2 = 1'b0;
  logic [2:0]  dbg_sel = 3'd0;
  logic [15:0] dbg;
  logic        ps2_clk = 1'b1, ps2_dat = 1'b1;
  logic [7:0]  data;
  logic        ready;
  logic        ack = 1'b0;

`ifdef PS2_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] POOL [24] = '{8'h1C, 8'h32, 8'h21, 8'h1A, 8'h4D, 8'h15, 8'h45,
    8'h16, 8'h46, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h12, 8'h59, 8'hF0, 8'hF0, 8'hE0, 8'h74,
    8'h6B, 8'h72, 8'h75, 8'h05, 8'h83};

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q [$];
  bit         m_shift = 0, m_ext = 0, m_brk = 0;
  logic [7:0] m_frames = 0, m_errs = 0, m_ovf = 0;
  bit         cons_en = 1;
  bit         busy = 0;

  ps2_controller #(.TIMEOUT_CYCLES(5000)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .clk1(clk1), .clk2(clk2),
    .dbg_sel(dbg_sel), .dbg(dbg), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .data(data), .ready(ready), .ack(ack)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_dbg(input string name, input logic [2:0] sel, input logic [15:0] exp);
    dbg_sel = sel;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check(name, dbg, exp);
  endtask

  // Key model: prefixes set flags, shift keys track make/break, other makes map via tables.
  task automatic model_scan(input logic [7:0] code);
    int v;
    v = -1;
    if (code == 8'hE0) m_ext = 1;
    else if (code == 8'hF0) m_brk = 1;
    else begin
      if (code == 8'h12 || code == 8'h59) m_shift = !m_brk;
      else if (!m_brk) begin
        if (m_ext) begin
          if (code == 8'h74) v = 8'hFE;
          if (code == 8'h6B) v = 8'hFD;
          if (code == 8'h72) v = 8'hFB;
          if (code == 8'h75) v = 8'hF7;
        end else begin
          for (int i = 0; i < 26; i++) if (code == LETTERS[i]) v = (m_shift ? 65 : 97) + i;
          for (int i = 0; i < 10; i++) if (code == DIGITS[i]) v = 48 + i;
          if (code == 8'h29) v = 32;
          if (code == 8'h5A) v = 10;
          if (code == 8'h66) v = 127;
          if (code == 8'h76) v = 27;
        end
      end
      m_brk = 0;
      m_ext = 0;
      if (v >= 0) begin
        if (!cons_en && exp_q.size() >= CAP) m_ovf++;
        else exp_q.push_back(v[7:0]);
      end
    end
  endtask

  task automatic ps2_edge(input logic bit_val);
    ps2_dat = bit_val;
    #200 ps2_clk = 1'b0;
    #200 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (!bad_par && !bad_stop) begin
      m_frames++;
      model_scan(b);
    end else begin
      m_errs++;
    end
    for (int i = 0; i < 11; i++) ps2_edge(bits[i]);
    ps2_dat = 1'b1;
    #600;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || ready || busy) && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    tests++;
    if (n >= 3000) begin
      fails++;
      $display("FAIL %s: drain timed out, pending=%0d ready=%0b", name, exp_q.size(), ready);
    end
  endtask

  // Consumer/monitor: compares each presented byte with the scoreboard, then acks it.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge CLOCK_50);
      if (cons_en && reset_n && ready) begin
        busy = 1;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_byte: got %h expected none", data);
        end else begin
          e = exp_q.pop_front();
          if (data !== e) begin
            fails++;
            $display("FAIL out_byte: got %h expected %h", data, e);
          end else begin
            $display("[TB] byte %h ok", data);
          end
        end
        ack = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        ack = 1'b0;
        repeat (6) @(negedge CLOCK_50);
        busy = 0;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLOCK_50);
    check("rst_data", {8'h00, data}, 16'h00FF);
    check("rst_ready", {15'b0, ready}, 16'h0000);
    check("rst_dbg", dbg, 16'h0000);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    send_frame(8'h1C, 0, 0);
    wait_drain("drain_a");
    check("hold_data", {8'h00, data}, 16'h0061);
    check("ready_clr", {15'b0, ready}, 16'h0000);
    check_dbg("dbg_last", 3'd0, 16'h1C61);

    send_frame(8'h12, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h12, 0, 0);
    send_frame(8'h1C, 0, 0);
    wait_drain("drain_shift");

    send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    wait_drain("drain_arrow");
    check_dbg("flags_clear", 3'd3, {13'b0, m_shift, m_ext, m_brk});

    send_frame(8'h1C, 1, 0);
    check_dbg("err_parity", 3'd1, {m_frames, m_errs});
    send_frame(8'h1C, 0, 1);
    check_dbg("err_stop", 3'd1, {m_frames, m_errs});
    check("no_ready_err", {15'b0, ready}, 16'h0000);

    for (int i = 0; i < 4; i++) ps2_edge(1'b0);
    ps2_dat = 1'b1;
    repeat (6000) @(posedge CLOCK_50);
    send_frame(8'h29, 0, 0);
    wait_drain("drain_timeout");
    check_dbg("timeout_idx", 3'd2, {m_ovf, 8'h00});

    cons_en = 0;
    send_frame(8'h1C, 0, 0);
    send_frame(8'h16, 0, 0);
    check("ovf_data", {8'h00, data}, 16'h0061);
    check("ovf_ready", {15'b0, ready}, 16'h0001);
    check_dbg("ovf_count", 3'd2, {m_ovf, 8'h00});
    cons_en = 1;
    wait_drain("drain_ovf");

    for (int n = 0; n < 120; n++) begin
      logic [7:0] code;
      bit bad;
      code = POOL[$urandom_range(0, 23)];
      bad  = ($urandom_range(0, 9) == 0);
      send_frame(code, bad && $urandom_range(0, 1) == 1, bad && $urandom_range(0, 1) == 0);
    end
    wait_drain("drain_random");
    check_dbg("rand_counts", 3'd1, {m_frames, m_errs});
    check_dbg("rand_ovf", 3'd2, {m_ovf, 8'h00});
    check_dbg("rand_flags", 3'd3, {13'b0, m_shift, m_ext, m_brk});
    clk1 = 1'b1;
    check_dbg("cpu_clks", 3'd4, 16'h0001);

    cons_en = 0;
    send_frame(8'h21, 0, 0);
    for (int i = 0; i < 5; i++) ps2_edge(1'b0);
    #5 reset_n = 1'b0;
    #5;
    check("mid_rst_data", {8'h00, data}, 16'h00FF);
    check("mid_rst_ready", {15'b0, ready}, 16'h0000);
    check("mid_rst_dbg", dbg, 16'h0000);
    exp_q.delete();
    m_shift = 0; m_ext = 0; m_brk = 0; m_frames = 0; m_errs = 0; m_ovf = 0;
    ps2_dat = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    cons_en = 1;
    check_dbg("post_rst_cnt", 3'd1, {m_frames, m_errs});
    send_frame(8'h32, 0, 0);
    wait_drain("drain_post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
